// File: rtl/nonce_sched_pkg.sv
// Shared types and helpers for the nonce scheduler: FSM state type, width defaults and a
// lowest-set-bit finder used to pick the next idle hash core.
package nonce_sched_pkg;

  localparam int unsigned NonceWDefault = 32;
  localparam int unsigned MaxCores      = 16;
  localparam int unsigned CoreIdxW      = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2,
    FINISH   = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic                valid;
    logic [CoreIdxW-1:0] idx;
  } lowest_t;

  // Scan from the top so the lowest set bit is the last one written.
  function automatic lowest_t lowest_set(input logic [MaxCores-1:0] mask);
    lowest_t res;
    res = '0;
    for (int i = MaxCores - 1; i >= 0; i--) begin
      if (mask[i]) begin
        res.valid = 1'b1;
        res.idx   = CoreIdxW'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/nonce_sched_pick.sv
// Combinational helper: lowest-index idle core for the next job, and the minimum
// winning nonce among the cores retiring in the current cycle.
module nonce_sched_pick
  import nonce_sched_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned NONCE_W   = NonceWDefault
) (
  input  logic [NUM_CORES-1:0]         idle_mask,
  input  logic [NUM_CORES-1:0]         cand_mask,
  input  logic [NUM_CORES*NONCE_W-1:0] cand_nonce,
  output logic                         pick_valid,
  output logic [CoreIdxW-1:0]          pick_idx,
  output logic                         cand_valid,
  output logic [NONCE_W-1:0]           cand_min
);

  logic [MaxCores-1:0] idle_pad;
  lowest_t             pick;

  always_comb begin
    idle_pad                = '0;
    idle_pad[NUM_CORES-1:0] = idle_mask;
    pick                    = lowest_set(idle_pad);
  end

  assign pick_valid = pick.valid;
  assign pick_idx   = pick.idx;

  always_comb begin
    cand_valid = 1'b0;
    cand_min   = '0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      if (cand_mask[i] && (!cand_valid || cand_nonce[i*NONCE_W +: NONCE_W] < cand_min)) begin
        cand_valid = 1'b1;
        cand_min   = cand_nonce[i*NONCE_W +: NONCE_W];
      end
    end
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Dispatches a nonce range across NUM_CORES hash cores and tracks the smallest winning nonce.
// Optional macro STOP_ON_FIND_EN: stop issuing new jobs once a winner has been recorded.
module nonce_scheduler
  import nonce_sched_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned NONCE_W   = NonceWDefault
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [NONCE_W-1:0]           nonce_base,
  input  logic [NONCE_W-1:0]           nonce_count,
  input  logic [NONCE_W-1:0]           target,
  output logic [NUM_CORES-1:0]         core_start,
  output logic [NUM_CORES*NONCE_W-1:0] core_nonce,
  input  logic [NUM_CORES-1:0]         core_done,
  input  logic [NUM_CORES*NONCE_W-1:0] core_hash,
  output logic                         busy,
  output logic                         done,
  output logic                         found,
  output logic [NONCE_W-1:0]           found_nonce,
  output logic [NONCE_W-1:0]           jobs_done
);

  sched_state_t               state_q, state_d;
  logic [NONCE_W-1:0]         target_q, target_d;
  logic [NONCE_W-1:0]         next_nonce_q, next_nonce_d;
  logic [NONCE_W-1:0]         remaining_q, remaining_d;
  logic [NONCE_W-1:0]         jobs_done_q, jobs_done_d;
  logic [NONCE_W-1:0]         found_nonce_q, found_nonce_d;
  logic                       found_q, found_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [NUM_CORES-1:0]       core_busy_q, core_busy_d;
  logic [NUM_CORES*NONCE_W-1:0] nonce_q, nonce_d;

  logic                       pick_valid;
  logic [CoreIdxW-1:0]        pick_idx;
  logic                       cand_valid;
  logic [NONCE_W-1:0]         cand_min;
  logic                       issue;
  logic                       stop_hit;
  logic [NUM_CORES-1:0]       issue_vec;
  logic [NUM_CORES-1:0]       retire_vec;
  logic [NUM_CORES-1:0]       cand_mask;
  logic [NONCE_W-1:0]         retire_cnt;

`ifdef STOP_ON_FIND_EN
  assign stop_hit = found_q;
`else
  assign stop_hit = 1'b0;
`endif

  nonce_sched_pick #(
    .NUM_CORES (NUM_CORES),
    .NONCE_W   (NONCE_W)
  ) u_pick (
    .idle_mask  (~core_busy_q),
    .cand_mask  (cand_mask),
    .cand_nonce (nonce_q),
    .pick_valid (pick_valid),
    .pick_idx   (pick_idx),
    .cand_valid (cand_valid),
    .cand_min   (cand_min)
  );

  // Idle mask comes from registered state, so a core freed this cycle is reissued next cycle.
  assign issue = (state_q == DISPATCH) && (remaining_q != '0) && pick_valid && !stop_hit;

  always_comb begin
    issue_vec  = '0;
    retire_vec = '0;
    cand_mask  = '0;
    retire_cnt = '0;
    nonce_d    = nonce_q;
    core_nonce = nonce_q;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      issue_vec[i] = issue && (pick_idx == CoreIdxW'(i));
      if (issue_vec[i]) begin
        nonce_d[i*NONCE_W +: NONCE_W]    = next_nonce_q;
        core_nonce[i*NONCE_W +: NONCE_W] = next_nonce_q;
      end
      retire_vec[i] = (state_q != IDLE) && core_done[i] && core_busy_q[i];
      cand_mask[i]  = retire_vec[i] && (core_hash[i*NONCE_W +: NONCE_W] < target_q);
      retire_cnt    = retire_cnt + NONCE_W'(retire_vec[i]);
    end
  end

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    busy_d        = busy_q;
    done_d        = done_q;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    jobs_done_d   = jobs_done_q + retire_cnt;
    core_busy_d   = (core_busy_q & ~retire_vec) | issue_vec;
    next_nonce_d  = issue ? next_nonce_q + 1'b1 : next_nonce_q;
    remaining_d   = issue ? remaining_q - 1'b1 : remaining_q;

    if (cand_valid) begin
      found_d       = 1'b1;
      found_nonce_d = (found_q && found_nonce_q < cand_min) ? found_nonce_q : cand_min;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          target_d      = target;
          next_nonce_d  = nonce_base;
          remaining_d   = nonce_count;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          found_d       = 1'b0;
          found_nonce_d = '0;
          jobs_done_d   = '0;
          state_d       = (nonce_count == '0) ? FINISH : DISPATCH;
        end
      end
      DISPATCH: begin
        if (remaining_d == '0 || stop_hit) state_d = DRAIN;
      end
      DRAIN: begin
        if (core_busy_q == '0) state_d = FINISH;
      end
      FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      target_q      <= '0;
      next_nonce_q  <= '0;
      remaining_q   <= '0;
      jobs_done_q   <= '0;
      found_nonce_q <= '0;
      found_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      core_busy_q   <= '0;
      nonce_q       <= '0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      next_nonce_q  <= next_nonce_d;
      remaining_q   <= remaining_d;
      jobs_done_q   <= jobs_done_d;
      found_nonce_q <= found_nonce_d;
      found_q       <= found_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      core_busy_q   <= core_busy_d;
      nonce_q       <= nonce_d;
    end
  end

  assign core_start  = issue_vec;
  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign found_nonce = found_nonce_q;
  assign jobs_done   = jobs_done_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Randomized bench for nonce_scheduler: emulated hash cores plus a job-level reference model
// (issue order, completion counts, minimum winning nonce), pinned by directed literal checks.
module tb_nonce_scheduler;

  localparam int unsigned NC = 4;
  localparam int unsigned W  = 32;
`ifdef STOP_ON_FIND_EN
  localparam bit StopEn = 1'b1;
`else
  localparam bit StopEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic [W-1:0]    nonce_base, nonce_count, target;
  logic [NC-1:0]   core_start, core_done;
  logic [NC*W-1:0] core_nonce, core_hash;
  logic            busy, done, found;
  logic [W-1:0]    found_nonce, jobs_done;

  always #5 clk = ~clk;

  nonce_scheduler #(
    .NUM_CORES (NC),
    .NONCE_W   (W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .nonce_base  (nonce_base),
    .nonce_count (nonce_count),
    .target      (target),
    .core_start  (core_start),
    .core_nonce  (core_nonce),
    .core_done   (core_done),
    .core_hash   (core_hash),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .found_nonce (found_nonce),
    .jobs_done   (jobs_done)
  );

  int checks = 0;
  int failures = 0;

  // Reference model and core emulation state
  int           cyc = 0;
  int           tmode = 0;
  bit           m_active = 1'b0;
  bit           m_done_lvl = 1'b0;
  int           m_acc = 0;
  int           m_all_cyc = -1;
  int           m_done_cyc = 0;
  logic [W-1:0] m_next, m_left, m_target, m_jobs, m_fnonce;
  bit           m_found = 1'b0;
  bit           run [NC];
  int           cnt [NC];
  logic [W-1:0] job [NC];
  int           pend_idx = -1;
  logic [W-1:0] dut_log[$];
  int           dut_off[$];
  logic [W-1:0] dut_prev_jobs = '0;
  logic [W-1:0] dut_max_step = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int job_lat(input logic [W-1:0] n);
    case (tmode)
      1, 2, 5: return 10;
      3: begin
        if (n == 32'h1C || n == 32'h20) return 4;
        if (n == 32'h1F) return 6;
        return 9;
      end
      4: return 5;
      default: return int'($urandom_range(12, 1));
    endcase
  endfunction

  function automatic logic [W-1:0] job_hash(input logic [W-1:0] n);
    case (tmode)
      1, 4: return 32'hFFFF_FFFF;
      2: return (n == 32'h106) ? 32'h5 : (n == 32'h109) ? 32'h1 : 32'hFFFF_FFFF;
      3: return (n == 32'h1F || n == 32'h20) ? 32'h0 : 32'hFFFF_FFFF;
      5: return (n == 32'h400) ? 32'h0 : 32'hFFFF_FFFF;
      default: return ($urandom_range(3, 0) == 0) ? W'($urandom_range(255, 0)) : W'($urandom);
    endcase
  endfunction

  task automatic check_cycle();
    int           exp_idx;
    logic [NC-1:0] exp_vec;
    logic [W-1:0] dn;
    bit           in_win;
    exp_idx = -1;
    exp_vec = '0;
    dn      = '0;
    if (core_start != '0) begin
      for (int i = NC - 1; i >= 0; i--) if (core_start[i]) dn = core_nonce[i*W +: W];
      dut_log.push_back(dn);
      dut_off.push_back(cyc - m_acc);
    end
    if (!m_active) begin
      chk("idle_core_start", W'(core_start), '0);
      chk("idle_busy", W'(busy), '0);
      chk("idle_done", W'(done), W'(m_done_lvl));
      chk("idle_jobs_done", jobs_done, m_jobs);
      chk("idle_found", W'(found), W'(m_found));
      chk("idle_found_nonce", found_nonce, m_found ? m_fnonce : '0);
    end else if (cyc > m_acc) begin
      if (m_left != '0 && !(StopEn && m_found))
        for (int i = NC - 1; i >= 0; i--) if (!run[i]) exp_idx = i;
      if (exp_idx >= 0) exp_vec[exp_idx] = 1'b1;
      chk("core_start", W'(core_start), W'(exp_vec));
      if (exp_idx >= 0) chk("core_nonce_issue", core_nonce[exp_idx*W +: W], m_next);
      for (int i = 0; i < NC; i++)
        if (run[i]) chk("core_nonce_hold", core_nonce[i*W +: W], job[i]);
      chk("jobs_done", jobs_done, m_jobs);
      chk("found", W'(found), W'(m_found));
      chk("found_nonce", found_nonce, m_found ? m_fnonce : '0);
      if (cyc > m_acc + 1 && jobs_done - dut_prev_jobs > dut_max_step)
        dut_max_step = jobs_done - dut_prev_jobs;
      if (done) begin
        chk("busy_at_done", W'(busy), '0);
        chk("done_only_when_complete", W'(m_all_cyc >= 0), 1);
        in_win = (m_all_cyc >= 0) && (cyc >= m_all_cyc + 1) && (cyc <= m_all_cyc + 4);
        chk("done_latency", W'(in_win), 1);
        m_active   = 1'b0;
        m_done_lvl = 1'b1;
        m_done_cyc = cyc;
        exp_idx    = -1;
      end else begin
        chk("busy", W'(busy), 1);
        if (m_all_cyc >= 0 && cyc > m_all_cyc + 4) begin
          chk("done_timeout", W'(done), 1);
          m_active = 1'b0;
        end
      end
    end
    dut_prev_jobs = jobs_done;
    pend_idx      = exp_idx;
  endtask

  task automatic cores_update();
    logic [W-1:0] h;
    bit           any_run;
    core_done = '0;
    core_hash = '0;
    for (int i = 0; i < NC; i++) begin
      if (run[i]) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          h                     = job_hash(job[i]);
          core_done[i]          = 1'b1;
          core_hash[i*W +: W]   = h;
          run[i]                = 1'b0;
          m_jobs                = m_jobs + 1;
          if (h < m_target) begin
            if (!m_found || job[i] < m_fnonce) m_fnonce = job[i];
            m_found = 1'b1;
          end
        end
      end
    end
    if (pend_idx >= 0) begin
      run[pend_idx] = 1'b1;
      cnt[pend_idx] = job_lat(m_next);
      job[pend_idx] = m_next;
      m_next        = m_next + 1;
      m_left        = m_left - 1;
    end
    // Stray completions on idle cores must be ignored; a zero hash would register as a win.
    if (tmode == 0)
      for (int i = 0; i < NC; i++)
        if (!run[i] && !core_done[i] && $urandom_range(15, 0) == 0) core_done[i] = 1'b1;
    any_run = 1'b0;
    for (int i = 0; i < NC; i++) any_run |= run[i];
    if (m_active && m_all_cyc < 0 && !any_run && (m_left == '0 || (StopEn && m_found)))
      m_all_cyc = cyc;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check_cycle();
    cores_update();
    start       = 1'b0;
    nonce_base  = $urandom;
    nonce_count = $urandom;
    target      = $urandom;
  endtask

  task automatic begin_search(input logic [W-1:0] b, input logic [W-1:0] c,
                              input logic [W-1:0] t);
    start         = 1'b1;
    nonce_base    = b;
    nonce_count   = c;
    target        = t;
    m_active      = 1'b1;
    m_done_lvl    = 1'b0;
    m_acc         = cyc;
    m_next        = b;
    m_left        = c;
    m_target      = t;
    m_jobs        = '0;
    m_found       = 1'b0;
    m_fnonce      = '0;
    m_all_cyc     = (c == '0) ? cyc : -1;
    dut_max_step  = '0;
    dut_log.delete();
    dut_off.delete();
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (m_active && n < budget);
    if (m_active) begin
      chk("search_timeout", W'(done), 1);
      m_active = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      run[i] = 1'b0;
      cnt[i] = 0;
      job[i] = '0;
    end
    m_active   = 1'b0;
    m_done_lvl = 1'b0;
    m_jobs     = '0;
    m_found    = 1'b0;
    m_fnonce   = '0;
    pend_idx   = -1;
    core_done  = '0;
    core_hash  = '0;
  endtask

  initial begin
    logic [W-1:0] b, c, t;
    reset_n     = 1'b0;
    start       = 1'b0;
    nonce_base  = '0;
    nonce_count = '0;
    target      = '0;
    model_reset();
    #1;
    chk("rst_busy", W'(busy), '0);
    chk("rst_core_start", W'(core_start), '0);
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Plain dispatch, no winners
    tmode = 1;
    begin_search(32'h100, 32'd4, 32'h0001_0000);
    run_until_done(200);
    chk("t1_starts", W'(dut_log.size()), 4);
    for (int i = 0; i < 4 && i < dut_log.size(); i++) begin
      chk("t1_nonce", dut_log[i], 32'h100 + W'(i));
      chk("t1_offset", W'(dut_off[i]), W'(i + 1));
    end
    chk("t1_done", W'(done), 1);
    chk("t1_found", W'(found), 0);
    chk("t1_jobs", jobs_done, 32'd4);

    // Smaller nonce wins, not smaller hash
    tmode = 2;
    begin_search(32'h100, 32'd10, 32'h10);
    run_until_done(300);
    chk("t2_found", W'(found), 1);
    chk("t2_found_nonce", found_nonce, 32'h106);
    chk("t2_jobs", jobs_done, 32'd10);

    // Two winners retiring in the same cycle
    tmode = 3;
    begin_search(32'h1C, 32'd5, 32'h10);
    run_until_done(300);
    chk("t3_found_nonce", found_nonce, 32'h1F);
    chk("t3_max_step", dut_max_step, 32'd2);
    chk("t3_jobs", jobs_done, 32'd5);

    // Nonce wrap
    tmode = 4;
    begin_search(32'hFFFF_FFFE, 32'd3, 32'h10);
    run_until_done(300);
    chk("t4_starts", W'(dut_log.size()), 3);
    if (dut_log.size() == 3) begin
      chk("t4_nonce0", dut_log[0], 32'hFFFF_FFFE);
      chk("t4_nonce1", dut_log[1], 32'hFFFF_FFFF);
      chk("t4_nonce2", dut_log[2], 32'h0000_0000);
    end
    chk("t4_jobs", jobs_done, 32'd3);

    // Empty range
    tmode = 1;
    begin_search(32'h55, 32'd0, 32'h10);
    run_until_done(50);
    chk("t5_latency", W'(m_done_cyc - m_acc), 32'd2);
    chk("t5_no_start", W'(dut_log.size()), 0);
    chk("t5_found", W'(found), 0);

    // Start while busy is ignored
    begin_search(32'h200, 32'd8, 32'h0001_0000);
    repeat (3) step();
    start       = 1'b1;
    nonce_base  = 32'h999;
    nonce_count = 32'd1;
    run_until_done(400);
    chk("t6_starts", W'(dut_log.size()), 8);
    for (int i = 0; i < 8 && i < dut_log.size(); i++)
      chk("t6_nonce", dut_log[i], 32'h200 + W'(i));

    // Asynchronous reset mid-dispatch
    tmode = 0;
    begin_search(32'h300, 32'd30, 32'hFFFF_FFFF);
    repeat (3) step();
    #1 reset_n = 1'b0;
    #1;
    chk("arst_core_start", W'(core_start), '0);
    chk("arst_core_nonce", W'(core_nonce != '0), 0);
    chk("arst_busy", W'(busy), '0);
    chk("arst_done", W'(done), '0);
    chk("arst_found", W'(found), '0);
    chk("arst_found_nonce", found_nonce, '0);
    chk("arst_jobs", jobs_done, '0);
    model_reset();
    repeat (2) step();
    reset_n = 1'b1;
    step();

`ifdef STOP_ON_FIND_EN
    tmode = 5;
    begin_search(32'h400, 32'd100, 32'h10);
    run_until_done(400);
    chk("t8_found_nonce", found_nonce, 32'h400);
    chk("t8_jobs_bound", W'(jobs_done <= NC + 1), 1);
`endif

    // Randomized searches
    for (int k = 0; k < 25; k++) begin
      tmode = 0;
      b = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 + W'($urandom_range(15, 0)) : W'($urandom);
      c = W'($urandom_range(40, 0));
      case ($urandom_range(3, 0))
        0: t = '0;
        1: t = 32'h100;
        2: t = W'($urandom);
        default: t = 32'hFFFF_FFFF;
      endcase
      begin_search(b, c, t);
      run_until_done(3000);
      if (t == '0) chk("tgt0_found", W'(found), 0);
      repeat ($urandom_range(2, 0)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
